// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic pipeline register with optional skid entry; stats counters under PIPE_STAGE_STATS_EN
module pipe_stage_reg #(
   parameter int CTRL_W = 16,
   parameter int DATA_W = 48,
   parameter int PT_CH  = 2,
   parameter int PT_W   = 18,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [CTRL_W-1:0]     in_ctrl,
   input  logic [DATA_W-1:0]     in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CTRL_W-1:0]     out_ctrl,
   output logic [DATA_W-1:0]     out_data,
   input  logic [PT_CH*PT_W-1:0] pt_in,
   output logic [PT_CH*PT_W-1:0] pt_out,
   output logic [1:0]            occupancy,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      bubble_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [CTRL_W-1:0]   main_ctrl;
   logic [DATA_W-1:0]   main_data;
   logic [CTRL_W-1:0]   skid_ctrl;
   logic [DATA_W-1:0]   skid_data;
   logic                main_valid;
   logic                accept;
   logic                drain;
   logic                load_main_in;
   logic                load_main_skid;
   logic                load_skid;

   // The head entry is valid whenever at least one entry is held.
   assign main_valid = (state != ST_EMPTY);
   assign out_valid  = main_valid & ~stall;
   assign out_ctrl   = out_valid ? main_ctrl : '0;
   assign out_data   = main_data;
   assign occupancy  = state;
   assign pt_out     = pt_in;

   // With the skid entry, in_ready only looks at registered state so out_ready never reaches it.
   assign in_ready = ~reset & ~stall & ~flush &
                     ((SKID != 0) ? (state != ST_TWO) : ((state == ST_EMPTY) | out_ready));

   assign accept = in_valid & in_ready;
   assign drain  = out_valid & out_ready;

   // State register; reset discards any held entries.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and entry-movement decode; flush overrides stall, stall freezes everything.
   always_comb begin
      state_nxt      = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         state_nxt = ST_EMPTY;
      end else if (!stall) begin
         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  state_nxt    = ST_ONE;
                  load_main_in = 1'b1;
               end
            end
            ST_ONE: begin
               if (accept && !drain) begin
                  state_nxt = ST_TWO;
                  load_skid = 1'b1;
               end else if (!accept && drain) begin
                  state_nxt = ST_EMPTY;
               end else if (accept && drain) begin
                  load_main_in = 1'b1;
               end
            end
            ST_TWO: begin
               if (drain) begin
                  state_nxt      = ST_ONE;
                  load_main_skid = 1'b1;
               end
            end
            default: state_nxt = ST_EMPTY;
         endcase
      end
   end

   // Entry storage; flush only clears control so stale data never enables anything downstream.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         main_ctrl <= '0;
         main_data <= '0;
         skid_ctrl <= '0;
         skid_data <= '0;
      end else if (flush) begin
         main_ctrl <= '0;
         skid_ctrl <= '0;
      end else begin
         if (load_main_in) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
         end else if (load_main_skid) begin
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
         end
         if (load_skid) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
         end
      end
   end

`ifdef PIPE_STAGE_STATS_EN
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] bubble_cnt_q;

   // Saturating statistics counters, cleared only by reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
         end
         if (!out_valid && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_q <= bubble_cnt_q + 1'b1;
         end
      end
   end

   assign stall_cnt  = stall_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
`else
   assign stall_cnt  = '0;
   assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

   localparam int CTRL_W = 16;
   localparam int DATA_W = 48;
   localparam int PT_CH  = 2;
   localparam int PT_W   = 18;
   localparam int CNT_W  = 4;

   logic                  clock = 1'b0;
   logic                  reset;
   logic                  stall;
   logic                  flush;
   logic                  in_valid;
   logic                  in_ready;
   logic [CTRL_W-1:0]     in_ctrl;
   logic [DATA_W-1:0]     in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [CTRL_W-1:0]     out_ctrl;
   logic [DATA_W-1:0]     out_data;
   logic [PT_CH*PT_W-1:0] pt_in;
   logic [PT_CH*PT_W-1:0] pt_out;
   logic [1:0]            occupancy;
   logic [CNT_W-1:0]      stall_cnt;
   logic [CNT_W-1:0]      bubble_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   pipe_stage_reg #(
      .CTRL_W(CTRL_W), .DATA_W(DATA_W), .PT_CH(PT_CH), .PT_W(PT_W), .SKID(1), .CNT_W(CNT_W)
   ) dut (
      .clock(clock), .reset(reset), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
      .pt_in(pt_in), .pt_out(pt_out), .occupancy(occupancy),
      .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic fill_two(input logic [15:0] ca, input logic [47:0] da,
                           input logic [15:0] cb, input logic [47:0] db);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_ctrl   = ca;
      in_data   = da;
      step();
      in_ctrl   = cb;
      in_data   = db;
      step();
      in_valid  = 1'b0;
      #1;
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
      in_ctrl = '0; in_data = '0; out_ready = 1'b0;
      pt_in = 36'h1_2345_6789;
      #2;
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_occ", 64'(occupancy), 64'd0);
      check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
      check("rst_bubble_cnt", 64'(bubble_cnt), 64'd0);
      check("rst_pt", 64'(pt_out), 64'h1_2345_6789);
      step();
      reset = 1'b0;
      #1;
      check("idle_in_ready", 64'(in_ready), 64'd1);

      // streaming: 16 entries back to back, one cycle latency
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         in_ctrl = 16'(i);
         in_data = 48'h100 + 48'(i);
         step();
         check("stream_valid", 64'(out_valid), 64'd1);
         check("stream_ctrl", 64'(out_ctrl), 64'(i));
         check("stream_data", 64'(out_data), 64'h100 + 64'(i));
         check("stream_occ", 64'(occupancy), 64'd1);
      end
      in_valid = 1'b0;
      step();
      check("stream_end_valid", 64'(out_valid), 64'd0);
      check("stream_end_ctrl", 64'(out_ctrl), 64'd0);
      check("stream_end_data", 64'(out_data), 64'h110);
      check("stream_end_occ", 64'(occupancy), 64'd0);

      // backpressure fills the skid entry
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_ctrl   = 16'hA0A0; in_data = 48'hAAAA;
      step();
      check("bp_occ1", 64'(occupancy), 64'd1);
      check("bp_ready1", 64'(in_ready), 64'd1);
      check("bp_ctrl1", 64'(out_ctrl), 64'hA0A0);
      in_ctrl   = 16'hB0B0; in_data = 48'hBBBB;
      step();
      check("bp_occ2", 64'(occupancy), 64'd2);
      check("bp_ready2", 64'(in_ready), 64'd0);
      check("bp_ctrl2", 64'(out_ctrl), 64'hA0A0);
      in_ctrl   = 16'hC0C0; in_data = 48'hCCCC;
      step();
      check("bp_full_hold_occ", 64'(occupancy), 64'd2);
      check("bp_full_hold_ctrl", 64'(out_ctrl), 64'hA0A0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      check("bp_head_a", 64'(out_ctrl), 64'hA0A0);
      step();
      check("bp_head_b", 64'(out_ctrl), 64'hB0B0);
      check("bp_head_b_data", 64'(out_data), 64'hBBBB);
      check("bp_occ_b", 64'(occupancy), 64'd1);
      step();
      check("bp_empty_valid", 64'(out_valid), 64'd0);
      check("bp_empty_occ", 64'(occupancy), 64'd0);

      // stall holds one entry and emits bubbles
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_ctrl   = 16'hBEEF; in_data = 48'hDEAD;
      step();
      in_valid  = 1'b0;
      stall     = 1'b1;
      pt_in     = 36'h0_0F0F_0F0F;
      #1;
      check("stall_valid", 64'(out_valid), 64'd0);
      check("stall_ctrl", 64'(out_ctrl), 64'd0);
      check("stall_ready", 64'(in_ready), 64'd0);
      check("stall_data", 64'(out_data), 64'hDEAD);
      check("stall_pt", 64'(pt_out), 64'h0_0F0F_0F0F);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_occ", 64'(occupancy), 64'd1);
         check("stall_hold_ctrl", 64'(out_ctrl), 64'd0);
      end
      stall = 1'b0;
      #1;
      check("unstall_valid", 64'(out_valid), 64'd1);
      check("unstall_ctrl", 64'(out_ctrl), 64'hBEEF);
      step();
      check("unstall_drained", 64'(occupancy), 64'd0);

      // flush with two entries and a pending input
      fill_two(16'h1111, 48'h1111_0000, 16'h2222, 48'h2222_0000);
      check("flush_pre_occ", 64'(occupancy), 64'd2);
      in_valid = 1'b1;
      in_ctrl  = 16'h3333; in_data = 48'h3333_0000;
      flush    = 1'b1;
      #1;
      check("flush_ready", 64'(in_ready), 64'd0);
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      #1;
      check("flush_occ", 64'(occupancy), 64'd0);
      check("flush_valid", 64'(out_valid), 64'd0);
      check("flush_ctrl", 64'(out_ctrl), 64'd0);
      check("flush_data_held", 64'(out_data), 64'h1111_0000);
      step();
      check("flush_not_taken", 64'(occupancy), 64'd0);

      // flush beats stall
      fill_two(16'h4444, 48'h4444_0000, 16'h5555, 48'h5555_0000);
      in_valid = 1'b1;
      in_ctrl  = 16'h6666; in_data = 48'h6666_0000;
      stall    = 1'b1;
      flush    = 1'b1;
      step();
      stall    = 1'b0;
      flush    = 1'b0;
      in_valid = 1'b0;
      #1;
      check("flush_stall_occ", 64'(occupancy), 64'd0);
      check("flush_stall_ctrl", 64'(out_ctrl), 64'd0);
      check("flush_stall_valid", 64'(out_valid), 64'd0);

      // asynchronous reset in the middle of a cycle with two entries held
      fill_two(16'h7777, 48'h7777_0000, 16'h8888, 48'h8888_0000);
      check("arst_pre_occ", 64'(occupancy), 64'd2);
      out_ready = 1'b1;
      #1;
      reset = 1'b1;
      #1;
      check("arst_occ", 64'(occupancy), 64'd0);
      check("arst_valid", 64'(out_valid), 64'd0);
      check("arst_ctrl", 64'(out_ctrl), 64'd0);
      check("arst_data", 64'(out_data), 64'd0);
      check("arst_ready", 64'(in_ready), 64'd0);
      check("arst_pt", 64'(pt_out), 64'h0_0F0F_0F0F);
      step();
      reset = 1'b0;
      stall = 1'b1;

      // statistics counters with CNT_W=4
      repeat (5) step();
`ifdef PIPE_STAGE_STATS_EN
      check("stats_stall5", 64'(stall_cnt), 64'd5);
`else
      check("stats_stall5", 64'(stall_cnt), 64'd0);
`endif
      repeat (15) step();
`ifdef PIPE_STAGE_STATS_EN
      check("stats_stall_sat", 64'(stall_cnt), 64'd15);
      check("stats_bubble_sat", 64'(bubble_cnt), 64'd15);
`else
      check("stats_stall_sat", 64'(stall_cnt), 64'd0);
      check("stats_bubble_sat", 64'(bubble_cnt), 64'd0);
`endif
      stall = 1'b0;
      flush = 1'b1;
      step();
      flush = 1'b0;
`ifdef PIPE_STAGE_STATS_EN
      check("stats_flush_keeps", 64'(stall_cnt), 64'd15);
`else
      check("stats_flush_keeps", 64'(stall_cnt), 64'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
